data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Word-organised data memory that responds to the execute stage's data-memory request signals: address, write data, write strobe, width and unsigned flag.
- Stores are performed at the clock edge of the request cycle, with byte-lane masking.
- Loads return extended data one cycle later, so the data lines up with the execute stage's registered outputs for the memory/writeback stage.
- Also provides one memory-mapped output register (LED/debug port).

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of two)
INIT_FILE, "", hex image loaded with $readmemh at elaboration when non-empty
MMIO_ADDR, 32'h8000_0000, byte address of the output register (word-aligned)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data; the low bytes are used for byte and half stores
req_write_i  input  1  store strobe (the requester has already gated it with its own stall-enable and valid)
req_read_i  input  1  load strobe (gated the same way as the store strobe)
req_width_i  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned_i  input  1  1 = zero-extend loads (funct3[2]); 0 = sign-extend
rdata_ro  output  32  extended load data
misalign_ro  output  1  the last request was misaligned or used the reserved width
range_err_ro  output  1  the last request fell outside both the RAM and MMIO_ADDR
mmio_out_ro  output  32  output register

Behaviour:
- Reset (async, rst_n low): rdata_ro=0, misalign_ro=0, range_err_ro=0, mmio_out_ro=0. RAM contents are not cleared. Reset asserted mid-access aborts that access: no write occurs.
- Word index = req_addr_i[log2(DEPTH_WORDS)+1:2]. The address is in the RAM when req_addr_i < DEPTH_WORDS*4.
- Alignment: a half access requires addr[0]=0; a word access requires addr[1:0]=00; a byte access is always aligned. Width 11 is treated as misaligned.
- Store (req_write_i=1, aligned, in range): written at the same rising edge.
  - Byte: lane addr[1:0] receives wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} receive wdata[15:0].
  - Word: all four lanes are written.
- Store to MMIO_ADDR: updates mmio_out_ro with the same lane rules. Lane offsets are allowed within the MMIO word, i.e. addr[31:2]==MMIO_ADDR[31:2].
- Load (req_read_i=1): rdata_ro updates at the next edge and has 1-cycle latency.
  - The selected lane(s) are shifted down and then sign- or zero-extended according to req_unsigned_i.
  - A load from MMIO returns mmio_out_ro with the same lane and extension rules.
  - A word load ignores req_unsigned_i.
- rdata_ro holds its value on every cycle without req_read_i. This covers stalls, because the requester only pulses the strobe when its stage advances.
- Misaligned, reserved-width or out-of-range request:
  - No memory or MMIO state changes.
  - A load sets rdata_ro=0.
  - The matching flag is set.
- Flag timing: misalign_ro and range_err_ro are updated at every edge where req_read_i or req_write_i is 1, and hold otherwise. They are not sticky across valid requests.
- req_read_i and req_write_i both 1: the write is performed and the read is ignored; rdata_ro holds.
- Load of an address stored in the previous cycle returns the new data (write occurs at the edge before the read edge).
- Memory is inferred as synchronous block RAM with 4 byte-write enables. Read data is registered, never combinational.

Decomposition:
- Shared definitions header (alongside the existing instruction/opcode definitions): WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10, WIDTH_RSVD=2'b11, and the default MMIO_ADDR.
- One natural combinational sub-module, dm_lane_steer:
  - Store direction: produces the 4-bit byte-enable and the replicated write word from addr[1:0], width and wdata.
  - Load direction: produces the extended read value from the raw word, addr[1:0], width and unsigned.
  - Used once for the store path and once for the load path. The load path uses the addr/width/unsigned values registered at the request edge.

Test Plan:
1. Reset then idle -> rdata_ro, misalign_ro, range_err_ro and mmio_out_ro are all 0. Asserting rst_n low mid-cycle clears the outputs immediately.
2. Word store 0x8899AABB to 0x10; next cycle half load 0x12 signed -> rdata_ro=0xFFFF8899. Half load 0x12 unsigned -> 0x00008899. Byte load 0x10 signed -> 0xFFFFFFBB.
3. Byte store 0x5A to 0x13 over 0x8899AABB -> word load 0x10 returns 0x5A99AABB. The other lanes are untouched.
4. Word load 0x11 -> misalign_ro=1, rdata_ro=0. Word store 0x12 -> misalign_ro=1 and memory unchanged. A following aligned load clears misalign_ro.
5. Word store 0x000000FF to MMIO_ADDR -> mmio_out_ro=0x000000FF. Load from DEPTH_WORDS*4 -> range_err_ro=1, rdata_ro=0.
6. Read strobe for one cycle, then 5 idle cycles -> rdata_ro is held constant. Simultaneous read and write of 0x20 with 0x1234 -> memory is written and rdata_ro keeps its prior value.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared data-memory definitions: access widths, default MMIO address and
// the alignment rule used by the request decoder.
package data_mem_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;
  localparam logic [1:0] WIDTH_RSVD = 2'b11;

  localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'h8000_0000;

  // The reserved width never counts as aligned, so it reports as misaligned.
  function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [1:0] width);
    logic ok;
    case (width)
      WIDTH_BYTE: ok = 1'b1;
      WIDTH_HALF: ok = ~addr_lo[0];
      WIDTH_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_lane_steer.sv
// Byte-lane steering: store-side byte enables and replicated write word, and
// load-side lane extraction with sign or zero extension.
module dm_lane_steer
  import data_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  width,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be     = 4'b0000;
    wword  = '0;
    rext   = '0;
    byte_v = raw[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (width)
      WIDTH_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rext  = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      end
      WIDTH_HALF: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rext  = {{16{~is_unsigned & half_v[15]}}, half_v};
      end
      WIDTH_WORD: begin
        be    = 4'b1111;
        wword = wdata;
        rext  = raw;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory with byte-lane stores, one-cycle extended loads
// and a single memory-mapped output register.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] MMIO_ADDR   = MMIO_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_write_i,
  input  logic        req_read_i,
  input  logic [1:0]  req_width_i,
  input  logic        req_unsigned_i,
  output logic [31:0] rdata_ro,
  output logic        misalign_ro,
  output logic        range_err_ro,
  output logic [31:0] mmio_out_ro
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  // Strobes are single-cycle qualifiers with no ready: every strobed request
  // is accepted at the edge that samples it; write wins when both are set.
  logic          aligned, in_ram, is_mmio, hit;
  logic          ram_we, mmio_we, rd_en;
  logic [AW-1:0] word_idx;
  logic [3:0]    st_be;
  logic [31:0]   st_wword;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_q;

  logic          ld_valid, ld_mmio, ld_unsigned;
  logic [1:0]    ld_addr_lo, ld_width;
  logic [31:0]   mmio_snap, ld_raw, ld_rext;

  logic [31:0]   unused_st_rext;
  logic [3:0]    unused_ld_be;
  logic [31:0]   unused_ld_wword;

  assign word_idx = req_addr_i[AW+1:2];
  assign aligned  = is_aligned(req_addr_i[1:0], req_width_i);
  assign in_ram   = ({1'b0, req_addr_i} < RAM_BYTES);
  assign is_mmio  = (req_addr_i[31:2] == MMIO_ADDR[31:2]);
  assign hit      = aligned && (in_ram || is_mmio);
  assign ram_we   = req_write_i && hit && !is_mmio;
  assign mmio_we  = req_write_i && hit && is_mmio;
  assign rd_en    = req_read_i && !req_write_i;

  dm_lane_steer u_store_steer (
    .addr_lo     (req_addr_i[1:0]),
    .width       (req_width_i),
    .is_unsigned (1'b0),
    .wdata       (req_wdata_i),
    .raw         (32'h0),
    .be          (st_be),
    .wword       (st_wword),
    .rext        (unused_st_rext)
  );

  // Held in reset means the edge performs no write, so an access in flight is aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[word_idx][8*b +: 8] <= st_wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) ram_q <= mem[word_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_out_ro  <= '0;
      misalign_ro  <= 1'b0;
      range_err_ro <= 1'b0;
      ld_valid     <= 1'b0;
      ld_mmio      <= 1'b0;
      ld_unsigned  <= 1'b0;
      ld_addr_lo   <= '0;
      ld_width     <= '0;
      mmio_snap    <= '0;
    end else begin
      if (mmio_we) begin
        for (int b = 0; b < 4; b++) begin
          if (st_be[b]) mmio_out_ro[8*b +: 8] <= st_wword[8*b +: 8];
        end
      end
      if (req_read_i || req_write_i) begin
        misalign_ro  <= ~aligned;
        range_err_ro <= ~(in_ram || is_mmio);
      end
      if (rd_en) begin
        ld_valid    <= hit;
        ld_mmio     <= is_mmio;
        ld_unsigned <= req_unsigned_i;
        ld_addr_lo  <= req_addr_i[1:0];
        ld_width    <= req_width_i;
        mmio_snap   <= mmio_out_ro;
      end
    end
  end

  // Load context is captured at the request edge, so the result stays stable until the next load.
  assign ld_raw = ld_mmio ? mmio_snap : ram_q;

  dm_lane_steer u_load_steer (
    .addr_lo     (ld_addr_lo),
    .width       (ld_width),
    .is_unsigned (ld_unsigned),
    .wdata       (32'h0),
    .raw         (ld_raw),
    .be          (unused_ld_be),
    .wword       (unused_ld_wword),
    .rext        (ld_rext)
  );

  assign rdata_ro = ld_valid ? ld_rext : '0;

endmodule

// File: tb/tb_data_mem.sv
// Randomised scoreboard bench for data_mem against a byte-addressed reference model.
module tb_data_mem;

  localparam int          DEPTH = 1024;
  localparam int          RAM_B = DEPTH * 4;
  localparam logic [31:0] MMIO  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_write_i, req_read_i, req_unsigned_i;
  logic [1:0]  req_width_i;
  logic [31:0] rdata_ro, mmio_out_ro;
  logic        misalign_ro, range_err_ro;

  data_mem #(.DEPTH_WORDS(DEPTH), .MMIO_ADDR(MMIO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_write_i    (req_write_i),
    .req_read_i     (req_read_i),
    .req_width_i    (req_width_i),
    .req_unsigned_i (req_unsigned_i),
    .rdata_ro       (rdata_ro),
    .misalign_ro    (misalign_ro),
    .range_err_ro   (range_err_ro),
    .mmio_out_ro    (mmio_out_ro)
  );

  // clock
  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  mem_b [RAM_B];
  logic [31:0] m_mmio, m_rdata;
  logic        m_mis, m_rng;

  // scoreboard: {mmio, rdata, misalign, range_err} expected after each edge
  logic [65:0] exp_q[$];
  logic [65:0] mon_e;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one request per cycle, model updated and expectation queued
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic re, input logic [1:0] w, input logic u);
    int size;
    logic in_ram, is_mm;
    logic [31:0] v;
    @(negedge clk);
    req_addr_i = a; req_wdata_i = wd; req_write_i = we; req_read_i = re;
    req_width_i = w; req_unsigned_i = u;
    size = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : (w == 2'd2) ? 4 : 0;
    if (we || re) begin
      if (size == 0) m_mis = 1'b1;
      else           m_mis = ((a % size) != 0);
      in_ram = (a < RAM_B);
      is_mm  = ((a >> 2) == (MMIO >> 2));
      m_rng  = !in_ram && !is_mm;
      if (we) begin
        if (!m_mis && !m_rng) begin
          for (int i = 0; i < size; i++) begin
            if (is_mm) m_mmio[8*(int'(a[1:0]) + i) +: 8] = wd[8*i +: 8];
            else       mem_b[a + i] = wd[8*i +: 8];
          end
        end
      end else if (m_mis || m_rng) begin
        m_rdata = 32'h0;
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) begin
          if (is_mm) v[8*i +: 8] = m_mmio[8*(int'(a[1:0]) + i) +: 8];
          else       v[8*i +: 8] = mem_b[a + i];
        end
        if (size < 4 && !u && v[8*size-1]) begin
          for (int j = 8*size; j < 32; j++) v[j] = 1'b1;
        end
        m_rdata = v;
      end
    end
    exp_q.push_back({m_mmio, m_rdata, m_mis, m_rng});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return MMIO + 32'($urandom_range(0, 3));
      1:       return 32'(RAM_B) + 32'($urandom_range(0, 255));
      2:       return 32'hFFFF_FFFC;
      default: return 32'($urandom_range(0, 255));
    endcase
  endfunction

  // monitor: every queued entry is compared just after its edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("mmio_out", mmio_out_ro, mon_e[65:34]);
      check("rdata", rdata_ro, mon_e[33:2]);
      check("misalign", {31'b0, misalign_ro}, {31'b0, mon_e[1]});
      check("range_err", {31'b0, range_err_ro}, {31'b0, mon_e[0]});
    end
  end

  initial begin
    rst_n = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; req_write_i = 1'b0; req_read_i = 1'b0;
    req_width_i = '0; req_unsigned_i = 1'b0;
    m_mmio = '0; m_rdata = '0; m_mis = 1'b0; m_rng = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", rdata_ro, 32'h0);
    check("reset_mmio", mmio_out_ro, 32'h0);
    check("reset_misalign", {31'b0, misalign_ro}, 32'h0);
    check("reset_range", {31'b0, range_err_ro}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int w = 0; w < 64; w++) step(32'(w * 4), $urandom, 1'b1, 1'b0, 2'd2, 1'b0);

    step(32'h10, 32'h8899_AABB, 1'b1, 1'b0, 2'd2, 1'b0);
    step(32'h12, 32'h0, 1'b0, 1'b1, 2'd1, 1'b0);
    step(32'h12, 32'h0, 1'b0, 1'b1, 2'd1, 1'b1);
    step(32'h10, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0);
    step(32'h13, 32'h5A, 1'b1, 1'b0, 2'd0, 1'b0);
    step(32'h10, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0);
    step(32'h11, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0);
    step(32'h12, 32'hCAFE_F00D, 1'b1, 1'b0, 2'd2, 1'b0);
    step(32'h10, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0);
    step(32'h10, 32'h0, 1'b0, 1'b1, 2'd3, 1'b0);
    step(MMIO, 32'h0000_00FF, 1'b1, 1'b0, 2'd2, 1'b0);
    step(32'(RAM_B), 32'h0, 1'b0, 1'b1, 2'd2, 1'b0);
    step(MMIO, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0);
    step(MMIO + 32'h2, 32'hA5A5_8001, 1'b1, 1'b0, 2'd1, 1'b0);
    step(MMIO + 32'h2, 32'h0, 1'b0, 1'b1, 2'd1, 1'b0);
    step(32'h10, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0);
    idle(5);
    step(32'h20, 32'h0000_1234, 1'b1, 1'b1, 2'd2, 1'b0);
    step(32'h20, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0);

    // asynchronous reset mid-cycle, with a store held across a reset edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rdata", rdata_ro, 32'h0);
    check("midrst_mmio", mmio_out_ro, 32'h0);
    check("midrst_misalign", {31'b0, misalign_ro}, 32'h0);
    check("midrst_range", {31'b0, range_err_ro}, 32'h0);
    m_mmio = '0; m_rdata = '0; m_mis = 1'b0; m_rng = 1'b0;
    @(negedge clk);
    req_addr_i = 32'h20; req_wdata_i = 32'hDEAD_BEEF; req_write_i = 1'b1; req_width_i = 2'd2;
    @(negedge clk);
    req_write_i = 1'b0;
    rst_n = 1'b1;
    step(32'h20, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0);
    step(32'h22, 32'h0, 1'b0, 1'b1, 2'd1, 1'b1);

    for (int n = 0; n < 400; n++) begin
      step(rand_addr(), $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    idle(3);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
